// File: rtl/md_sequencer_pkg.sv
// rtl/md_sequencer_pkg.sv - MD op encodings, state types and default latencies for md_sequencer.
// Shared by the default build and the MD_ITER_DIV_EN build.
package md_sequencer_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef enum logic [1:0] {
    DV_IDLE = 2'd0,
    DV_STEP = 2'd1,
    DV_FIX  = 2'd2
  } md_div_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;
  localparam int MD_ITER_DIV_CYCLES = 34;
  localparam int MD_CNT_W           = 8;

  // Divides magnitudes so 0x80000000 / -1 wraps to 0x80000000 without host overflow.
  function automatic logic [63:0] md_divide(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
    logic [31:0] ma, mb, q, r;
    logic        na, nb;
    na = sgn & a[31];
    nb = sgn & b[31];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    if (mb == 32'd0) mb = 32'd1;
    q = ma / mb;
    r = ma % mb;
    if (na ^ nb) q = -q;
    if (na) r = -r;
    return {r, q};
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// rtl/md_div_iter.sv - 32-step restoring divider with sign fix-up, built only under MD_ITER_DIV_EN.
// Load at the start edge, 32 step edges, one fix-up edge; done pulses with quot/rem valid.
`ifdef MD_ITER_DIV_EN
module md_div_iter
  import md_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  md_div_state_e st_q, st_d;
  logic [4:0]    step_q, step_d;
  logic [31:0]   r_q, r_d, q_q, q_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d;
  logic          nq_q, nq_d, nr_q, nr_d, done_q, done_d;
  logic [32:0]   shifted, diff;

  assign shifted = {r_q, q_q[31]};
  assign diff    = shifted - {1'b0, d_q};

  always_comb begin
    st_d   = st_q;
    step_d = step_q;
    r_d    = r_q;
    q_d    = q_q;
    d_d    = d_q;
    nq_d   = nq_q;
    nr_d   = nr_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    done_d = 1'b0;
    case (st_q)
      DV_IDLE: if (start) begin
        nq_d   = sign & (dividend[31] ^ divisor[31]);
        nr_d   = sign & dividend[31];
        r_d    = 32'd0;
        q_d    = (sign & dividend[31]) ? -dividend : dividend;
        d_d    = (sign & divisor[31]) ? -divisor : divisor;
        step_d = 5'd31;
        st_d   = DV_STEP;
      end
      DV_STEP: begin
        // A borrow means the trial subtraction is discarded and the quotient bit is 0.
        q_d = {q_q[30:0], ~diff[32]};
        r_d = diff[32] ? shifted[31:0] : diff[31:0];
        if (step_q == 5'd0) st_d = DV_FIX;
        else step_d = step_q - 5'd1;
      end
      DV_FIX: begin
        quot_d = nq_q ? -q_q : q_q;
        rem_d  = nr_q ? -r_q : r_q;
        done_d = 1'b1;
        st_d   = DV_IDLE;
      end
      default: st_d = DV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= DV_IDLE;
      step_q <= 5'd0;
      r_q    <= 32'd0;
      q_q    <= 32'd0;
      d_q    <= 32'd0;
      nq_q   <= 1'b0;
      nr_q   <= 1'b0;
      quot_q <= 32'd0;
      rem_q  <= 32'd0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      step_q <= step_d;
      r_q    <= r_d;
      q_q    <= q_d;
      d_q    <= d_d;
      nq_q   <= nq_d;
      nr_q   <= nr_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule
`endif

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - HI/LO multiply/divide sequencer with busy counter and D-stage stall.
// MD_ITER_DIV_EN selects the iterative divider (34 cycles); otherwise behavioral divide, DIV_CYCLES.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        istart,
  input  logic [2:0]  iop,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iflush,
  input  logic        iDmd,
  output logic        oBusy,
  output logic        oStall,
  output logic [31:0] oHI,
  output logic [31:0] oLO
);

  localparam logic [MD_CNT_W-1:0] MULT_LAST = MD_CNT_W'(MULT_CYCLES - 1);
`ifdef MD_ITER_DIV_EN
  localparam logic [MD_CNT_W-1:0] DIV_LAST = MD_CNT_W'(MD_ITER_DIV_CYCLES - 1);
`else
  localparam logic [MD_CNT_W-1:0] DIV_LAST = MD_CNT_W'(DIV_CYCLES - 1);
`endif

  md_op_e              op;
  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0]         hi_q, hi_d, lo_q, lo_d;
  logic                busy_q, busy_d, divz_q, divz_d;
  logic                is_mul, is_div, acc, acc_md;
  logic [63:0]         prod;
  logic [31:0]         commit_hi, commit_lo;

  assign op     = md_op_e'(iop);
  assign is_mul = (op == MD_MULT) | (op == MD_MULTU);
  assign is_div = (op == MD_DIV) | (op == MD_DIVU);
  assign acc    = istart & ~iflush & (state_q == ST_IDLE);
  assign acc_md = acc & (is_mul | is_div);
  assign oStall = iDmd & (busy_q | acc_md);

  assign prod = (op == MD_MULT) ? ({{32{iA[31]}}, iA} * {{32{iB[31]}}, iB})
                                : ({32'd0, iA} * {32'd0, iB});

`ifdef MD_ITER_DIV_EN
  logic        div_done;
  logic [31:0] div_quot, div_rem;

  md_div_iter u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (acc & is_div),
    .sign     (op == MD_DIV),
    .dividend (iA),
    .divisor  (iB),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  // done only pulses for a divide, exactly in its final busy cycle.
  assign commit_hi = div_done ? div_rem  : pend_hi_q;
  assign commit_lo = div_done ? div_quot : pend_lo_q;
`else
  logic [63:0] div_res;

  assign div_res   = md_divide(iA, iB, op == MD_DIV);
  assign commit_hi = pend_hi_q;
  assign commit_lo = pend_lo_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    divz_d    = divz_q;
    case (state_q)
      ST_IDLE: if (acc) begin
        case (op)
          MD_MTHI: hi_d = iA;
          MD_MTLO: lo_d = iA;
          MD_MULT, MD_MULTU: begin
            {pend_hi_d, pend_lo_d} = prod;
            divz_d  = 1'b0;
            cnt_d   = MULT_LAST;
            busy_d  = 1'b1;
            state_d = ST_BUSY;
          end
          MD_DIV, MD_DIVU: begin
`ifndef MD_ITER_DIV_EN
            {pend_hi_d, pend_lo_d} = div_res;
`endif
            divz_d  = (iB == 32'd0);
            cnt_d   = DIV_LAST;
            busy_d  = 1'b1;
            state_d = ST_BUSY;
          end
          default: ;
        endcase
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          if (!divz_q) begin
            hi_d = commit_hi;
            lo_d = commit_lo;
          end
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      divz_q    <= divz_d;
    end
  end

  assign oBusy = busy_q;
  assign oHI   = hi_q;
  assign oLO   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - scoreboard bench for md_sequencer in the default (MD_ITER_DIV_EN undefined) build.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, istart, iflush, iDmd;
  logic [2:0]  iop;
  logic [31:0] iA, iB;
  logic        oBusy, oStall;
  logic [31:0] oHI, oLO;

  int          vectors = 0;
  int          errors  = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .istart (istart),
    .iop    (iop),
    .iA     (iA),
    .iB     (iB),
    .iflush (iflush),
    .iDmd   (iDmd),
    .oBusy  (oBusy),
    .oStall (oStall),
    .oHI    (oHI),
    .oLO    (oLO)
  );

  // Reference HI/LO model, updated when a start is driven; the post-commit pair is queued.
  task automatic model_push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    case (op)
      MD_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        {m_hi, m_lo} = p;
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = p;
      end
      MD_DIV: if (b != 32'd0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'd0;
        end else begin
          ia   = a;
          ib   = b;
          m_lo = ia / ib;
          m_hi = ia % ib;
        end
      end
      MD_DIVU: if (b != 32'd0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: ;
    endcase
    sb_q.push_back({m_hi, m_lo});
  endtask

  task automatic drive_idle();
    istart = 1'b0;
    iop    = MD_NONE;
    iA     = 32'd0;
    iB     = 32'd0;
    iflush = 1'b0;
  endtask

  // Called at a negedge: drives one start cycle, then counts busy cycles (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    istart = 1'b1;
    iop    = op;
    iA     = a;
    iB     = b;
    model_push(op, a, b);
    @(negedge clk);
    drive_idle();
    busy_cycles = 0;
    while (oBusy && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    iDmd  = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", oBusy); end
    vectors++; if (oHI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", oHI); end
    vectors++; if (oLO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", oLO); end
    vectors++; if (oStall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", oStall); end
    iDmd = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    sb_q.delete();
    @(negedge clk);
  endtask

  task automatic test_mult();
    int bc; logic [63:0] exp;
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, bc);
    exp = sb_q.pop_front();
    vectors++; if (bc !== MC) begin errors++; $display("FAIL mult_latency: got %0d want %0d", bc, MC); end
    vectors++; if ({oHI, oLO} !== exp || exp !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      errors++; $display("FAIL mult_result: got %h want %h", {oHI, oLO}, 64'hFFFF_FFFF_FFFF_FFFA); end
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, bc);
    exp = sb_q.pop_front();
    vectors++; if ({oHI, oLO} !== exp || exp !== 64'h0000_0002_FFFF_FFFA) begin
      errors++; $display("FAIL multu_result: got %h want %h", {oHI, oLO}, 64'h0000_0002_FFFF_FFFA); end
  endtask

  task automatic test_div();
    int bc; logic [63:0] exp;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, bc);
    exp = sb_q.pop_front();
    vectors++; if (bc !== DC) begin errors++; $display("FAIL div_latency: got %0d want %0d", bc, DC); end
    vectors++; if ({oHI, oLO} !== exp || exp !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL div_result: got %h want %h", {oHI, oLO}, 64'hFFFF_FFFF_FFFF_FFFD); end
    run_op(MD_DIVU, 32'hFFFF_FFF9, 32'd2, bc);
    exp = sb_q.pop_front();
    vectors++; if ({oHI, oLO} !== exp) begin
      errors++; $display("FAIL divu_result: got %h want %h", {oHI, oLO}, exp); end
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    exp = sb_q.pop_front();
    vectors++; if ({oHI, oLO} !== 64'h0000_0000_8000_0000) begin
      errors++; $display("FAIL div_overflow: got %h want %h", {oHI, oLO}, 64'h0000_0000_8000_0000); end
  endtask

  task automatic test_div_zero();
    int bc; logic [63:0] exp;
    run_op(MD_MTHI, 32'h1234, 32'd0, bc);
    exp = sb_q.pop_front();
    vectors++; if (oHI !== 32'h1234 || bc !== 0) begin
      errors++; $display("FAIL mthi: got %h/%0d want 1234/0", oHI, bc); end
    run_op(MD_MTLO, 32'h1234, 32'd0, bc);
    exp = sb_q.pop_front();
    vectors++; if ({oHI, oLO} !== exp) begin
      errors++; $display("FAIL mtlo: got %h want %h", {oHI, oLO}, exp); end
    run_op(MD_DIV, 32'd5, 32'd0, bc);
    exp = sb_q.pop_front();
    vectors++; if (bc !== DC) begin errors++; $display("FAIL divz_latency: got %0d want %0d", bc, DC); end
    vectors++; if ({oHI, oLO} !== 64'h0000_1234_0000_1234) begin
      errors++; $display("FAIL divz_result: got %h want %h", {oHI, oLO}, 64'h0000_1234_0000_1234); end
  endtask

  task automatic test_stall();
    logic [63:0] exp;
    iDmd   = 1'b1;
    istart = 1'b1;
    iop    = MD_MULT;
    iA     = 32'd7;
    iB     = 32'd9;
    model_push(MD_MULT, 32'd7, 32'd9);
    #1;
    vectors++; if (oStall !== 1'b1 || oBusy !== 1'b0) begin
      errors++; $display("FAIL stall_c0: got stall=%b busy=%b want 1/0", oStall, oBusy); end
    for (int c = 1; c <= MC; c++) begin
      @(negedge clk);
      istart = (c == 2);
      iA     = 32'd1;
      iB     = 32'd1;
      #1;
      vectors++; if (oStall !== 1'b1 || oBusy !== 1'b1) begin
        errors++; $display("FAIL stall_c%0d: got stall=%b busy=%b want 1/1", c, oStall, oBusy); end
    end
    @(negedge clk);
    drive_idle();
    #1;
    exp = sb_q.pop_front();
    vectors++; if (oStall !== 1'b0 || oBusy !== 1'b0) begin
      errors++; $display("FAIL stall_end: got stall=%b busy=%b want 0/0", oStall, oBusy); end
    vectors++; if ({oHI, oLO} !== exp) begin
      errors++; $display("FAIL stall_result: got %h want %h", {oHI, oLO}, exp); end
    iDmd = 1'b0;
    @(negedge clk);
    vectors++; if (oBusy !== 1'b0) begin
      errors++; $display("FAIL dropped_start: got busy=%b want 0", oBusy); end
  endtask

  task automatic test_flush();
    int bc; logic [63:0] exp;
    istart = 1'b1;
    iop    = MD_MTHI;
    iA     = 32'hDEAD;
    iflush = 1'b1;
    @(negedge clk);
    drive_idle();
    vectors++; if (oHI !== m_hi || oBusy !== 1'b0) begin
      errors++; $display("FAIL flush_mthi: got hi=%h busy=%b want %h/0", oHI, oBusy, m_hi); end
    istart = 1'b1;
    iop    = MD_MULTU;
    iA     = 32'h0001_0000;
    iB     = 32'h0001_0000;
    model_push(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    drive_idle();
    iflush = 1'b1;
    @(negedge clk);
    iflush = 1'b0;
    bc = 1;
    while (oBusy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    exp = sb_q.pop_front();
    vectors++; if ({oHI, oLO} !== exp || bc !== MC) begin
      errors++; $display("FAIL flush_busy: got %h/%0d want %h/%0d", {oHI, oLO}, bc, exp, MC); end
  endtask

  task automatic test_reset_mid_op();
    int bc; logic [63:0] exp;
    istart = 1'b1;
    iop    = MD_DIV;
    iA     = 32'd100;
    iB     = 32'd7;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    iDmd  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if (oBusy !== 1'b0 || oStall !== 1'b0) begin
      errors++; $display("FAIL midrst_ctl: got busy=%b stall=%b want 0/0", oBusy, oStall); end
    vectors++; if ({oHI, oLO} !== 64'd0) begin
      errors++; $display("FAIL midrst_hilo: got %h want 0", {oHI, oLO}); end
    iDmd = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    run_op(MD_MTLO, 32'h55, 32'd0, bc);
    exp = sb_q.pop_front();
    vectors++; if ({oHI, oLO} !== exp || oLO !== 32'h55) begin
      errors++; $display("FAIL midrst_mtlo: got %h want %h", {oHI, oLO}, exp); end
  endtask

  task automatic test_back_to_back();
    int          bc, want;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    logic [2:0]  ops[6] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
    for (int i = 0; i < 10; i++) begin
      op = ops[$urandom_range(5, 0)];
      a  = $urandom;
      b  = ($urandom_range(4, 0) == 0) ? 32'd0 : $urandom;
      if (i == 0) b = 32'd0;
      want = (op == MD_MULT || op == MD_MULTU) ? MC :
             (op == MD_DIV  || op == MD_DIVU)  ? DC : 0;
      run_op(op, a, b, bc);
      exp = sb_q.pop_front();
      vectors++; if (bc !== want) begin
        errors++; $display("FAIL b2b_latency[%0d]: op=%0d got %0d want %0d", i, op, bc, want); end
      vectors++; if ({oHI, oLO} !== exp) begin
        errors++; $display("FAIL b2b_result[%0d]: op=%0d a=%h b=%h got %h want %h", i, op, a, b, {oHI, oLO}, exp); end
    end
  endtask

  initial begin
    reset = 1'b1;
    iDmd  = 1'b0;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall();
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
